vga_sync_detect: RTL and testbench

//  Receive-side counterpart of the 640x480 VGA sync generator. Samples hsync/vsync
//  (active-high) on the pixel clock enable and measures line length, hsync width,

---
 rtl/vga_sync_detect_if.sv | 13 +
 rtl/vga_sync_detect.sv | 144 ++++++++++++++
 tb/tb_vga_sync_detect.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vga_sync_detect_if.sv
// Sync-input / measurement-output bundle between a VGA sync source and the detector.
interface vga_sync_detect_if #(parameter int CW = 10);
  logic          p_tick, hsync, vsync;
  logic          locked, lock_err, frame_start;
  logic [CW-1:0] h_total, h_sync_w, v_total, v_sync_w, rx_x, rx_y;

  modport master (output p_tick, hsync, vsync,
                  input  locked, lock_err, frame_start,
                  input  h_total, h_sync_w, v_total, v_sync_w, rx_x, rx_y);
  modport slave  (input  p_tick, hsync, vsync,
                  output locked, lock_err, frame_start,
                  output h_total, h_sync_w, v_total, v_sync_w, rx_x, rx_y);
endinterface

// File: rtl/vga_sync_detect.sv
// Measures incoming hsync/vsync timing, locks after stable frames and recovers
// the pixel/line position of the incoming stream.
module vga_sync_detect #(
  parameter int CW          = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  vga_sync_detect_if.slave sd
);
  localparam logic [CW-1:0] MAX = '1;
  localparam int MW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  typedef struct packed {
    logic [CW-1:0] line;
    logic [CW-1:0] hsw;
    logic [CW-1:0] frm;
    logic [CW-1:0] vsw;
  } timing_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    return (inc && v != MAX) ? v + 1'b1 : v;
  endfunction

  state_t        state, state_n;
  logic          hs_s1, hs_s2, vs_s1, vs_s2;
  logic          hs_rise, hs_fall, vs_rise, vs_fall;
  logic [CW-1:0] h_cnt, v_cnt, h_inc, v_inc;
  logic [CW-1:0] line_len, hs_w, frm_len, vs_w, line_len_n, frm_len_n;
  timing_t       cur, ref_q, meas_q;
  logic          ref_valid, ref_diff, lock_mis, timeout;
  logic [MW-1:0] match_cnt;
  logic          ref_clr, ref_load, match_inc, meas_load, meas_clr, fs_set;
  logic          locked_q, lock_err_q, frame_start_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) {hs_s1, hs_s2, vs_s1, vs_s2} <= '0;
    else begin
      hs_s1 <= sd.hsync; hs_s2 <= hs_s1;
      vs_s1 <= sd.vsync; vs_s2 <= vs_s1;
    end

  assign hs_rise = hs_s1 & ~hs_s2;
  assign hs_fall = ~hs_s1 & hs_s2;
  assign vs_rise = vs_s1 & ~vs_s2;
  assign vs_fall = ~vs_s1 & vs_s2;

  // Latched lengths include the event clock itself, so the frame compare sees
  // the line count including an hsync rise on the same clock.
  assign h_inc      = sat_inc(h_cnt, sd.p_tick);
  assign v_inc      = sat_inc(v_cnt, hs_rise);
  assign line_len_n = hs_rise ? h_inc : line_len;
  assign frm_len_n  = vs_rise ? v_inc : frm_len;
  assign cur        = '{line: line_len_n, hsw: hs_w, frm: frm_len_n, vsw: vs_w};

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      h_cnt <= '0; v_cnt <= '0;
      line_len <= '0; hs_w <= '0; frm_len <= '0; vs_w <= '0;
    end else begin
      h_cnt    <= hs_rise ? CW'(sd.p_tick) : h_inc;
      v_cnt    <= vs_rise ? CW'(hs_rise) : v_inc;
      line_len <= line_len_n;
      frm_len  <= frm_len_n;
      if (hs_fall) hs_w <= h_inc;
      if (vs_fall) vs_w <= v_inc;
    end

  assign timeout  = (h_cnt == MAX) || (v_cnt == MAX);
  assign ref_diff = !ref_valid || (cur != ref_q);
  assign lock_mis = (hs_rise && cur.line != meas_q.line) ||
                    (vs_rise && (cur.frm != meas_q.frm || cur.vsw != meas_q.vsw ||
                                 cur.hsw != meas_q.hsw));

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= SEARCH;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    if (timeout) state_n = SEARCH;
    else case (state)
      SEARCH:  if (vs_rise) state_n = MEASURE;
      MEASURE: if (vs_rise && !ref_diff && match_cnt == MW'(LOCK_FRAMES - 1)) state_n = LOCKED;
      LOCKED:  if (lock_mis) state_n = MEASURE;
      default: state_n = SEARCH;
    endcase
  end

  always_comb begin
    ref_clr   = 1'b0;
    ref_load  = 1'b0;
    match_inc = 1'b0;
    meas_load = 1'b0;
    fs_set    = 1'b0;
    if (!timeout) case (state)
      SEARCH:  ref_clr = vs_rise;
      MEASURE: if (vs_rise) begin
        ref_load  = ref_diff;
        meas_load = (state_n == LOCKED);
        match_inc = !ref_diff && (state_n != LOCKED);
      end
      LOCKED: begin
        ref_load = lock_mis;
        fs_set   = vs_rise && !lock_mis;
      end
      default: ;
    endcase
    meas_clr = (state == LOCKED) && (state_n != LOCKED);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ref_q <= '0; ref_valid <= 1'b0; match_cnt <= '0; meas_q <= '0;
      locked_q <= 1'b0; lock_err_q <= 1'b0; frame_start_q <= 1'b0;
    end else begin
      if (ref_clr) begin
        ref_valid <= 1'b0;
        match_cnt <= '0;
      end else if (ref_load) begin
        ref_q     <= cur;
        ref_valid <= 1'b1;
        match_cnt <= '0;
      end else if (meas_load) match_cnt <= '0;
      else if (match_inc)     match_cnt <= match_cnt + 1'b1;
      // Published measurements only move on lock entry or loss.
      if (meas_load)     meas_q <= ref_q;
      else if (meas_clr) meas_q <= '0;
      locked_q      <= (state_n == LOCKED);
      lock_err_q    <= meas_clr;
      frame_start_q <= fs_set;
    end

  assign sd.locked      = locked_q;
  assign sd.lock_err    = lock_err_q;
  assign sd.frame_start = frame_start_q;
  assign sd.h_total     = meas_q.line;
  assign sd.h_sync_w    = meas_q.hsw;
  assign sd.v_total     = meas_q.frm;
  assign sd.v_sync_w    = meas_q.vsw;
  assign sd.rx_x        = h_cnt;
  assign sd.rx_y        = v_cnt;
endmodule

// File: tb/tb_vga_sync_detect.sv
// Drives synthetic VGA-style timings and checks lock, measurements, pulses and counters.
module tb_vga_sync_detect;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_sync_detect_if #(.CW(CW)) sd();
  vga_sync_detect #(.CW(CW), .LOCK_FRAMES(2)) dut (.clk(clk), .reset(reset), .sd(sd));

  int n_cmp = 0, n_err = 0;
  int le_cnt = 0, fs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sd.lock_err === 1'b1)    le_cnt++;
    if (sd.frame_start === 1'b1) fs_cnt++;
  end

  // One pixel period: pins change together with the p_tick clock, p_tick idle the next.
  task automatic tick_cyc(input bit hs, input bit vs, input bit chk_en, input int ex, input int ey);
    @(negedge clk);
    if (chk_en) begin
      chk("rx_x", 32'(sd.rx_x), 32'(ex));
      chk("rx_y", 32'(sd.rx_y), 32'(ey));
    end
    sd.p_tick = 1'b1; sd.hsync = hs; sd.vsync = vs;
    @(negedge clk);
    sd.p_tick = 1'b0;
  endtask

  // Lines of len ticks; hsync high for hsw ticks from hss; vsync level held per line.
  task automatic drive_frame(input int h, input int hss, input int hsw, input int v,
                             input int vsw, input int stretch, input int nlines);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = h + ((l == stretch) ? 1 : 0);
      for (int x = 0; x < len; x++)
        tick_cyc(x >= hss && x < hss + hsw, l < vsw, l == 1 && x == hss, h - 1, 1);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"},   32'(sd.locked), 0);
    chk({tag, "_lock_err"}, 32'(sd.lock_err), 0);
    chk({tag, "_fstart"},   32'(sd.frame_start), 0);
    chk({tag, "_h_total"},  32'(sd.h_total), 0);
    chk({tag, "_v_total"},  32'(sd.v_total), 0);
    chk({tag, "_rx_x"},     32'(sd.rx_x), 0);
    chk({tag, "_rx_y"},     32'(sd.rx_y), 0);
  endtask

  task automatic chk_meas(input string tag, input int h, input int hsw, input int v, input int vsw);
    chk({tag, "_h_total"},  32'(sd.h_total), 32'(h));
    chk({tag, "_h_sync_w"}, 32'(sd.h_sync_w), 32'(hsw));
    chk({tag, "_v_total"},  32'(sd.v_total), 32'(v));
    chk({tag, "_v_sync_w"}, 32'(sd.v_sync_w), 32'(vsw));
  endtask

  task automatic apply_reset(input bit check);
    @(negedge clk);
    reset = 1'b0; sd.p_tick = 1'b0; sd.hsync = 1'b0; sd.vsync = 1'b0;
    #1;
    if (check) chk_zero("async_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Lock needs LOCK_FRAMES+2 vsync rises from a cold start: arm, reference, 2 matches.
  task automatic acquire(input string tag, input int h, input int hss, input int hsw,
                         input int v, input int vsw);
    repeat (3) drive_frame(h, hss, hsw, v, vsw, -1, v);
    chk({tag, "_unlocked3"}, 32'(sd.locked), 0);
    drive_frame(h, hss, hsw, v, vsw, -1, v);
    chk({tag, "_locked4"}, 32'(sd.locked), 1);
    chk_meas(tag, h, hsw, v, vsw);
  endtask

  task automatic run_round(input int h, input int hss, input int hsw, input int v, input int vsw);
    int f0, e0;
    apply_reset(1'b0);
    acquire("acq", h, hss, hsw, v, vsw);

    f0 = fs_cnt; e0 = le_cnt;
    repeat (2) drive_frame(h, hss, hsw, v, vsw, -1, v);
    chk("fstart_per_frame", 32'(fs_cnt - f0), 2);
    chk("no_lock_err", 32'(le_cnt - e0), 0);
    chk("still_locked", 32'(sd.locked), 1);

    e0 = le_cnt;
    drive_frame(h, hss, hsw, v, vsw, 2, v);
    chk("stretch_err", 32'(le_cnt - e0), 1);
    chk("stretch_unlock", 32'(sd.locked), 0);
    repeat (2) drive_frame(h, hss, hsw, v, vsw, -1, v);
    chk("relock_wait", 32'(sd.locked), 0);
    drive_frame(h, hss, hsw, v, vsw, -1, v);
    chk("relock", 32'(sd.locked), 1);
    chk_meas("relock", h, hsw, v, vsw);

    drive_frame(h, hss, hsw, v, vsw, -1, 3);
    apply_reset(1'b1);
    acquire("rst_acq", h, hss, hsw, v, vsw);

    f0 = fs_cnt; e0 = le_cnt;
    repeat (1100) tick_cyc(1'b0, 1'b0, 1'b0, 0, 0);
    chk("timeout_err", 32'(le_cnt - e0), 1);
    chk("timeout_fstart", 32'(fs_cnt - f0), 0);
    chk("timeout_locked", 32'(sd.locked), 0);
    chk_meas("timeout", 0, 0, 0, 0);
  endtask

  initial begin
    int h, hss, hsw, v, vsw;
    reset = 1'b1; sd.p_tick = 1'b0; sd.hsync = 1'b0; sd.vsync = 1'b0;
    apply_reset(1'b1);
    chk_meas("rst", 0, 0, 0, 0);

    run_round(10, 5, 2, 8, 1);
    for (int r = 0; r < 3; r++) begin
      h   = $urandom_range(30, 12);
      hsw = $urandom_range(h / 3, 1);
      hss = $urandom_range(h - hsw - 1, 1);
      v   = $urandom_range(12, 6);
      vsw = $urandom_range(v - 3, 1);
      run_round(h, hss, hsw, v, vsw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule
